reg_mul_seq: RTL and testbench
==============================

Name: reg_mul_seq

Overview:
- Iterative signed 16x16 multiplier in the datapath, next to the 8-entry register file.
- Consumes the register file's two read-port values (SR1_OUT/SR2_OUT) as operands.
- Produces a write-back request (LD_REG, DR, DATA) that drives the register file's write port directly.
- One shift-add iteration per clock; the datapath controller stalls on Busy.

Parameters:
WIDTH, 16, operand/result width and iteration count; register file data width must match.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
Start  input  1  request; sampled only in IDLE.
A  input  WIDTH  multiplicand, from register file SR1_OUT.
B  input  WIDTH  multiplier, from register file SR2_OUT.
DR_IN  input  3  destination register index for the result.
Busy  output  1  high in RUN and WB.
Done  output  1  one-cycle pulse, coincident with LD_REG.
Overflow  output  1  sticky per operation: signed product does not fit WIDTH bits.
LD_REG  output  1  register file write enable.
DR  output  3  register file write index.
DATA  output  WIDTH  register file write data (low WIDTH bits of the product).

Behaviour:
- Reset (async, Reset=0): state=IDLE, iteration counter=0, Busy=0, Done=0, LD_REG=0, Overflow=0, DR=0, DATA=0, internal accumulator/operand registers=0.
- States: IDLE, RUN, WB.
- IDLE:
  - On a rising edge with Start=1, latch A, B and DR_IN, then go to RUN with counter=0.
  - At latch time: sign = A[WIDTH-1]^B[WIDTH-1]. Operands are stored as unsigned magnitudes (-32768 has magnitude 0x8000).
  - Start=0: stay in IDLE.
- RUN:
  - Each edge performs one iteration: if multiplier LSB=1, add the 2*WIDTH-bit shifted multiplicand to the 2*WIDTH-bit accumulator; shift the multiplier right and the multiplicand left; counter++.
  - After the edge where counter reaches WIDTH-1 (WIDTH iterations total), go to WB.
  - On that same edge, register DATA = low WIDTH bits of the sign-corrected product (two's-complement negate if sign=1).
  - On that same edge, register Overflow = 1 iff the signed 2*WIDTH-bit product is not equal to the sign-extension of its low WIDTH bits. DR = latched DR_IN.
- WB:
  - LD_REG=1 and Done=1 for exactly one cycle; the register file writes on the following edge; go to IDLE.
- Latency: Start sampled at edge 0; LD_REG/Done high between edges WIDTH and WIDTH+1 (16 and 17 by default); the register updates at edge 17.
- Busy = (state != IDLE), decoded from the state register with no combinational path from Start.
- Start while Busy (including during the WB cycle) is ignored; no queuing.
- A new Start may be accepted on the edge that leaves WB? No: Start is only sampled in IDLE, so the earliest restart is the edge after WB exits, i.e. edge 18.
- A, B and DR_IN may change freely after the latch edge; the result depends only on the latched values.
- Zero operands still take the full WIDTH iterations; there is no early termination.
- DATA, DR and Overflow hold their last values until the next WB update. LD_REG and Done are 0 outside WB.
- Reset asserted mid-RUN or in WB: immediate return to IDLE with all outputs at reset values; no write-back is issued.

Test Plan:
- A=3, B=5, DR_IN=2, Start pulsed one cycle -> Busy=1 from edge 0; LD_REG=Done=1 only between edges 16 and 17; DATA=0x000F, DR=2, Overflow=0.
- A=0xFFF9 (-7), B=6, DR_IN=7 -> DATA=0xFFD6 (-42), Overflow=0; A=0x8000, B=1 -> DATA=0x8000, Overflow=0.
- A=0x0100, B=0x0100 -> DATA=0x0000, Overflow=1; then A=0x8000, B=0xFFFF (-1) -> DATA=0x8000, Overflow=1.
- Start held high continuously with A, B changed during RUN -> exactly one write-back per operation using the originally latched operands; the next operation latches at edge 18.
- Reset driven low at edge 8 of RUN -> Busy, Done, LD_REG, DATA and Overflow drop to 0 asynchronously; no LD_REG pulse occurs; after release, 2*3 completes normally with DATA=0x0006.
- A=0, B=0x1234 -> the full 16-cycle latency is preserved; DATA=0x0000, Overflow=0.

Source files
------------

// File: rtl/reg_mul_seq_if.sv
// reg_mul_seq_if: operand request and register-file write-back bundle
// for the iterative multiplier.
interface reg_mul_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       dr_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             ld_reg;
  logic [2:0]       dr;
  logic [WIDTH-1:0] data;
  modport master (output start, a, b, dr_in, input busy, done, overflow, ld_reg, dr, data);
  modport slave  (input start, a, b, dr_in, output busy, done, overflow, ld_reg, dr, data);
endinterface

// File: rtl/reg_mul_seq.sv
// reg_mul_seq: signed WIDTHxWIDTH shift-add multiplier, one iteration per clock,
// issuing a single register-file write-back of the low WIDTH product bits.
module reg_mul_seq #(parameter int WIDTH = 16) (
  input logic        clk,
  input logic        reset,
  reg_mul_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, WB = 2'd2;
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nx, prod;
  logic [WIDTH-1:0]   mplier, mag_a, mag_b, data;
  logic [2:0]         dr_q, dr;
  logic               sign, ovf, ovf_nx, last;
  always_comb begin
    mag_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    mag_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
    acc_nx = acc + (mplier[0] ? mcand : '0);
    prod   = sign ? -acc_nx : acc_nx;
    ovf_nx = prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]};
    last   = cnt == CW'(WIDTH - 1);
  end
  always_comb begin
    bus.busy     = state != IDLE;
    bus.ld_reg   = state == WB;
    bus.done     = state == WB;
    bus.data     = data;
    bus.dr       = dr;
    bus.overflow = ovf;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign   <= 1'b0;
      dr_q   <= '0;
      dr     <= '0;
      data   <= '0;
      ovf    <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        state  <= RUN;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        dr_q   <= bus.dr_in;
      end
    end else if (state == RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        state <= WB;
        data  <= prod[WIDTH-1:0];
        ovf   <= ovf_nx;
        dr    <= dr_q;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_reg_mul_seq.sv
// tb_reg_mul_seq: directed vectors feed a scoreboard queue; a negedge monitor
// pops and checks each write-back, including the cycle it appears on.
module tb_reg_mul_seq;
  typedef struct {
    logic [15:0] d;
    logic [2:0]  r;
    logic        o;
    int          t;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];
  reg_mul_seq_if #(.WIDTH(16)) bus();
  reg_mul_seq #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // Scoreboard monitor: every write-back must match the oldest pending operation.
  always @(negedge clk) begin
    if (reset && (bus.ld_reg || bus.done)) begin
      chk("done_eq_ld_reg", {31'd0, bus.done}, {31'd0, bus.ld_reg});
      if (q.size() == 0) begin
        chk("spurious_ld_reg", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data", {16'd0, bus.data}, {16'd0, e.d});
        chk("dr", {29'd0, bus.dr}, {29'd0, e.r});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.o});
        chk("ld_cycle", cyc, e.t);
      end
    end
  end
  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    chk("busy_timeout", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] r,
                    input logic [15:0] ed, input logic eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.dr_in = r;
    q.push_back('{ed, r, eo, cyc + 17});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.dr_in = 3'($urandom);
    chk("busy_after_latch", {31'd0, bus.busy}, 32'd1);
    wait_idle();
  endtask
  initial begin
    int l;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.dr_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ld_reg", {31'd0, bus.ld_reg}, 32'd0);
    chk("rst_data", {16'd0, bus.data}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b1;
    op(16'h0003, 16'h0005, 3'd2, 16'h000F, 1'b0);
    op(16'hFFF9, 16'h0006, 3'd7, 16'hFFD6, 1'b0);
    op(16'h8000, 16'h0001, 3'd3, 16'h8000, 1'b0);
    op(16'hFFFD, 16'hFFFC, 3'd5, 16'h000C, 1'b0);
    op(16'h7FFF, 16'h7FFF, 3'd6, 16'h0001, 1'b1);
    op(16'h0100, 16'h0100, 3'd4, 16'h0000, 1'b1);
    op(16'h8000, 16'hFFFF, 3'd1, 16'h8000, 1'b1);
    // Abort mid-RUN: outputs clear without a clock edge and no write-back follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h0005;
    bus.dr_in = 3'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_ld_reg", {31'd0, bus.ld_reg}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_data", {16'd0, bus.data}, 32'd0);
    chk("abort_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("abort_dr", {29'd0, bus.dr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    op(16'h0002, 16'h0003, 3'd1, 16'h0006, 1'b0);
    op(16'h0000, 16'h1234, 3'd2, 16'h0000, 1'b0);
    // Start held high: second operation latches at edge 18 with the operands present then.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h0002;
    bus.b = 16'h0007;
    bus.dr_in = 3'd4;
    l = cyc + 1;
    q.push_back('{16'h000E, 3'd4, 1'b0, l + 16});
    q.push_back('{16'h0033, 3'd5, 1'b0, l + 34});
    @(negedge clk);
    bus.a = 16'h0011;
    bus.b = 16'h0003;
    bus.dr_in = 3'd5;
    repeat (18) @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    chk("held_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
